// File: rtl/gpp16_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : gpp16_wb_regfile
//  Brief    : GPP16 writeback stage. Holds the 8 x 16-bit register file, the
//             6-bit flags register, a retired-operation counter and a sticky
//             illegal-opcode flag. Provides same-cycle bypassed operands and
//             merged flags back to the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module gpp16_wb_regfile #(
  parameter int CONTROL_ALU = 5,
  parameter int NREGS       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [CONTROL_ALU-1:0]   wb_func,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [15:0]              wb_y,
  input  logic [5:0]               wb_flags,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [15:0]              ra_data,
  output logic [15:0]              rb_data,
  output logic [5:0]               flags_q,
  output logic [5:0]               flags_fwd,
  output logic [15:0]              retire_cnt,
  output logic                     illegal_op
);

  // --------------------------------------------------------------------------
  // Function-code class boundaries
  // --------------------------------------------------------------------------
  localparam logic [CONTROL_ALU-1:0] c_FUNC_ARITH_HI = CONTROL_ALU'(3);
  localparam logic [CONTROL_ALU-1:0] c_FUNC_SHIFT_LO = CONTROL_ALU'(13);
  localparam logic [CONTROL_ALU-1:0] c_FUNC_SHIFT_HI = CONTROL_ALU'(15);
  localparam logic [CONTROL_ALU-1:0] c_FUNC_CMP      = CONTROL_ALU'(17);

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [15:0] r_regs [NREGS];
  logic [5:0]  r_flags;
  logic [15:0] r_retire_cnt;
  logic        r_illegal;

  // --------------------------------------------------------------------------
  // Operation decode (only meaningful while wb_valid is high)
  // --------------------------------------------------------------------------
  logic w_is_arith;
  logic w_is_shift;
  logic w_is_cmp;
  logic w_is_legal;
  logic w_writes;
  logic w_we;
  logic w_retire;
  logic w_illegal;

  assign w_is_arith = (wb_func <= c_FUNC_ARITH_HI);
  assign w_is_shift = (wb_func >= c_FUNC_SHIFT_LO) && (wb_func <= c_FUNC_SHIFT_HI);
  assign w_is_cmp   = (wb_func == c_FUNC_CMP);
  assign w_is_legal = (wb_func <= c_FUNC_CMP);
  // Codes 0..15 produce a register result; NOP, CMP and illegal codes do not.
  assign w_writes   = (wb_func <= c_FUNC_SHIFT_HI);

  assign w_we       = wb_valid && w_writes;
  assign w_retire   = wb_valid && w_is_legal;
  assign w_illegal  = wb_valid && !w_is_legal;

  // --------------------------------------------------------------------------
  // Flag merge: each operation class owns a disjoint subset of flag bits
  // --------------------------------------------------------------------------
  logic [5:0] w_flags_next;

  // Merge incoming ALU flags into the held flags according to operation class
  always_comb begin
    w_flags_next = r_flags;
    if (wb_valid) begin
      if (w_is_arith) begin
        w_flags_next[4] = wb_flags[4];
      end
      if (w_is_shift) begin
        w_flags_next[3] = wb_flags[3];
      end
      if (w_is_cmp) begin
        w_flags_next[5] = wb_flags[5];
        w_flags_next[2] = wb_flags[2];
        w_flags_next[1] = wb_flags[1];
        w_flags_next[0] = wb_flags[0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports with writeback bypass
  // --------------------------------------------------------------------------
  logic        w_ra_hit;
  logic        w_rb_hit;
  logic [15:0] w_ra_raw;
  logic [15:0] w_rb_raw;

  assign w_ra_hit = w_we && (wb_rd == ra_addr);
  assign w_rb_hit = w_we && (wb_rd == rb_addr);

  // Select bypassed result or stored register for each operand port
  always_comb begin
    w_ra_raw = w_ra_hit ? wb_y : r_regs[ra_addr];
    w_rb_raw = w_rb_hit ? wb_y : r_regs[rb_addr];
  end

  // While reset is asserted the stored state is already zero, but the bypass
  // path would still expose wb_y; force every forwarded value to zero.
  assign ra_data    = rst ? 16'h0000 : w_ra_raw;
  assign rb_data    = rst ? 16'h0000 : w_rb_raw;
  assign flags_fwd  = rst ? 6'b000000 : w_flags_next;

  assign flags_q    = r_flags;
  assign retire_cnt = r_retire_cnt;
  assign illegal_op = r_illegal;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------

  // Register file write from the ALU result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else if (w_we) begin
      r_regs[wb_rd] <= wb_y;
    end
  end

  // Flags register; w_flags_next equals r_flags whenever nothing merges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 6'b000000;
    end else begin
      r_flags <= w_flags_next;
    end
  end

  // Retired-operation counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= 16'h0000;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 16'h0001;
    end
  end

  // Sticky illegal-opcode indicator, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/gpp16_wb_regfile.md
# gpp16_wb_regfile

Writeback stage and architectural state for the GPP16 datapath, directly downstream of the 16-bit ALU. Captures each ALU result into an 8 x 16-bit register file, merges ALU flag outputs into a persistent 6-bit flags register according to operation class, and supplies operands and flags back to the ALU's `a`, `b` and `flagsin` inputs. Also keeps a retired-operation counter and a sticky illegal-opcode indicator.

## Interface
Parameters:
- CONTROL_ALU, 5, width of the ALU function code; must match the ALU instance.
- NREGS, 8, number of 16-bit registers; register address width is clog2(NREGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- wb_valid  input  1  a completed ALU operation is presented this cycle.
- wb_func  input  CONTROL_ALU  function code of that operation (0..17).
- wb_rd  input  clog2(NREGS)  destination register.
- wb_y  input  16  ALU result `y`.
- wb_flags  input  6  ALU `flagsout`.
- ra_addr, rb_addr  input  clog2(NREGS) each  operand read addresses.
- ra_data, rb_data  output  16 each  operand data, feeding ALU `a` and `b`.
- flags_q  output  6  registered flags {ZF,OF/CO,CF,PF,GF,LF} = bits 5..0.
- flags_fwd  output  6  flags value after this cycle's merge, feeding ALU `flagsin`.
- retire_cnt  output  16  count of legal operations accepted.
- illegal_op  output  1  sticky: an operation with wb_func > 17 was presented.

## Operation
- Function classes: arithmetic 0-3 (ADD,SUB,MUL,DIV); logic/move 4-12; shift 13-15; NOP 16; CMP 17; illegal 18-31.
- Register write when wb_valid and func in 0..15: reg[wb_rd] <= wb_y. NOP, CMP and illegal codes never write.
- Flag merge when wb_valid (bits not listed hold their value):
  - arithmetic: bit4 <= wb_flags[4].
  - shift: bit3 <= wb_flags[3].
  - CMP: bits 5,2,1,0 <= wb_flags bits 5,2,1,0.
  - logic/move, NOP, illegal: no change.
- flags_fwd = merged value when wb_valid, else flags_q (combinational).
- Read bypass: ra_data/rb_data return wb_y when wb_valid, the op writes, and wb_rd equals the read address; otherwise the stored register. Both ports may hit the same address.
- retire_cnt increments by 1 for every wb_valid with func 0..17; wraps 0xFFFF -> 0x0000; illegal codes do not increment.
- illegal_op sets on wb_valid with func > 17; cleared only by rst. The illegal operation has no other effect.
- With wb_valid low: no state changes; inputs other than read addresses are don't-care.

## Timing
- Reset (async, immediate, regardless of wb_valid): all registers 0x0000, flags_q 6'b0, retire_cnt 0, illegal_op 0. ra_data/rb_data/flags_fwd read 0 while rst is high (bypass disabled during reset).
- Write latency: state updates on the rising edge where wb_valid is high; visible in stored state the following cycle, and same-cycle via bypass/flags_fwd.
- No backpressure: the stage accepts one operation every cycle.
- Read ports and flags_fwd are purely combinational from registered state and wb_* inputs; no combinational path from ra_addr to flags.
- Reset deasserted mid-stream: first edge after deassertion with wb_valid high is processed normally.

## Test plan
- Reset: assert rst mid-cycle with wb_valid=1, func=0 -> all outputs 0 immediately; no write occurs at the next edge while rst high.
- ADD write + bypass: wb_valid=1, func=0, rd=3, y=0x2712, flags=6'b010000 -> ra_addr=3 reads 0x2712 same cycle; after edge reg3=0x2712, flags_q=6'b010000, retire_cnt=1.
- CMP merge: preset flags_q=6'b011000 via ADD+LSL, then CMP with wb_flags=6'b100001 -> flags_q=6'b111001; no register changes.
- Shift carry: func=13, rd=1, y=0x8000, flags=6'b001000 -> reg1=0x8000, bit3 set, bit4 unchanged.
- Illegal: func=20, rd=2, y=0xFFFF -> reg2 unchanged, flags unchanged, retire_cnt unchanged, illegal_op=1 and stays 1 until rst.
- Counter wrap: 65536 consecutive NOPs -> retire_cnt returns to 0x0000, no register or flag change.
